// File: rtl/usb_frame_tx.sv
// usb_frame_tx: captures a 528-bit averaged frame and streams 64 data bytes plus the USB CRC16, low byte first.
// Define USB_FRAME_TX_BUF_EN to add a one-frame pending buffer behind the frame being sent.
//
// state  | meaning
// IDLE   | no frame in flight, outputs quiet
// SEND   | streaming data bytes from shift_q[7:0]
// CRC_LO | sending (~crc)[7:0]
// CRC_HI | sending (~crc)[15:8]; its handshake ends the frame
module usb_frame_tx #(
    parameter int FRAME_W = 528,
    parameter int NBYTES  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_drop
);

    localparam int DATA_W = FRAME_W - 16;
    localparam logic [5:0] LAST = 6'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, CRC_LO, CRC_HI} state_t;

    state_t              state_q, state_nxt;
    logic [DATA_W-1:0]   shift_q;
    logic [15:0]         crc_q;
    logic [5:0]          count_q;
    logic                drop_q;
    logic                hs;
    logic                load;
    logic                load_new;
    logic                drop_nxt;
    logic                unused_low;

`ifdef USB_FRAME_TX_BUF_EN
    logic                pend_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic                load_pend;
    logic                store;
`endif

    assign unused_low = ^frame_in[15:0];

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign hs = tx_valid && tx_ready;

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        load_new  = 1'b0;
        drop_nxt  = 1'b0;
`ifdef USB_FRAME_TX_BUF_EN
        load_pend = 1'b0;
        store     = 1'b0;
`endif
        case (state_q)
            IDLE: if (frame_valid) begin
                load      = 1'b1;
                load_new  = 1'b1;
                state_nxt = SEND;
            end
            SEND:   if (hs && count_q == LAST) state_nxt = CRC_LO;
            CRC_LO: if (hs) state_nxt = CRC_HI;
            CRC_HI: if (hs) begin
                state_nxt = IDLE;
`ifdef USB_FRAME_TX_BUF_EN
                if (pend_q) begin
                    load      = 1'b1;
                    load_pend = 1'b1;
                    state_nxt = SEND;
                end else
`endif
                if (frame_valid) begin
                    load      = 1'b1;
                    load_new  = 1'b1;
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A strobe that does not start a frame is either parked or rejected.
        if (frame_valid && state_q != IDLE && !load_new) begin
`ifdef USB_FRAME_TX_BUF_EN
            if (!pend_q) store = 1'b1;
            else         drop_nxt = 1'b1;
`else
            drop_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            crc_q   <= 16'hFFFF;
            count_q <= 6'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            drop_q  <= drop_nxt;
            if (load_new)
                shift_q <= frame_in[FRAME_W-1:16];
`ifdef USB_FRAME_TX_BUF_EN
            else if (load_pend)
                shift_q <= pend_data_q;
`endif
            else if (state_q == SEND && hs)
                shift_q <= shift_q >> 8;

            if (load) begin
                crc_q   <= 16'hFFFF;
                count_q <= 6'd0;
            end else if (state_q == SEND && hs) begin
                crc_q <= crc16_byte(crc_q, shift_q[7:0]);
                if (count_q != LAST)
                    count_q <= count_q + 6'd1;
            end
        end
    end

`ifdef USB_FRAME_TX_BUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else if (store) begin
            pend_q      <= 1'b1;
            pend_data_q <= frame_in[FRAME_W-1:16];
        end else if (load_pend) begin
            pend_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            SEND:    tx_byte = shift_q[7:0];
            CRC_LO:  tx_byte = ~crc_q[7:0];
            CRC_HI:  tx_byte = ~crc_q[15:8];
            default: tx_byte = 8'h00;
        endcase
    end

    assign tx_valid   = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == CRC_HI) && tx_ready;
    assign frame_drop = drop_q;

endmodule

// File: tb/tb_usb_frame_tx.sv
// tb_usb_frame_tx: randomized stimulus with a queue-based scoreboard for usb_frame_tx.
// Expectations follow USB_FRAME_TX_BUF_EN when it is defined.
module tb_usb_frame_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic [527:0] frame_in;
    logic         frame_valid;
    logic         tx_ready;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         busy;
    logic         frame_done;
    logic         frame_drop;

`ifdef USB_FRAME_TX_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    always #5 clk = ~clk;

    usb_frame_tx dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid), .busy(busy),
        .frame_done(frame_done), .frame_drop(frame_drop)
    );

    int          tests = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          mon_idx = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    int          frames_exp = 0;
    int          drops_exp = 0;
    bit          gap_seen = 1'b0;
    bit          rdy_rand = 1'b0;
    logic [15:0] mon_crc = 16'hFFFF;
    bit          stall_v = 1'b0;
    logic [7:0]  stall_b = 8'h00;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [511:0] d);
        logic [15:0] c;
        logic [15:0] t;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            c = crc_step(c, d[8*i +: 8]);
        end
        t = ~c;
        exp_q.push_back(t[7:0]);
        exp_q.push_back(t[15:8]);
    endtask

    task automatic strobe(input logic [527:0] f, input bit accept);
        @(posedge clk); #1;
        frame_in    = f;
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        if (accept) begin
            push_frame(f[527:16]);
            frames_exp++;
        end else begin
            drops_exp++;
        end
    endtask

    task automatic wait_idx(input int k);
        int n;
        n = 0;
        while (mon_idx < k && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            tests++; errors++;
            $display("FAIL wait_idx timeout: index %0d required %0d", mon_idx, k);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            tests++; errors++;
            $display("FAIL wait_idle timeout: %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    function automatic logic [527:0] rand_frame();
        logic [527:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[32*i+16 +: 32] = $urandom;
        f[15:0] = 16'($urandom);
        return f;
    endfunction

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches stall/frame rules.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            mon_idx = 0;
            mon_crc = 16'hFFFF;
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("valid_hold", 32'(tx_valid), 32'd1);
                check("stall_byte", 32'(tx_byte), 32'(stall_b));
            end
            stall_v = tx_valid && !tx_ready;
            stall_b = tx_byte;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(tx_byte), 32'(e));
                end
                mon_crc = crc_step(mon_crc, tx_byte);
                check("frame_done_hs", 32'(frame_done), 32'(mon_idx == 65));
                if (mon_idx == 65) begin
                    check("crc_residual", 32'(mon_crc), 32'h0000B001);
                    done_cnt++;
                    mon_idx = 0;
                    mon_crc = 16'hFFFF;
                end else begin
                    mon_idx++;
                end
            end else begin
                check("frame_done_idle", 32'(frame_done), 32'd0);
            end
            if (frame_drop) drop_cnt++;
            if (!busy && exp_q.size() != 0) gap_seen = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [527:0] fa, fy, fz;
        logic [7:0]   first_bytes[5];
        rst = 1'b1; frame_valid = 1'b0; frame_in = '0;
        first_bytes[0] = 8'h04; first_bytes[1] = 8'h03; first_bytes[2] = 8'h02;
        first_bytes[3] = 8'h01; first_bytes[4] = 8'h05;
        fa = '0;
        for (int k = 0; k < 16; k++) fa[32*k+16 +: 32] = 32'h01020304 + 32'(k);
        fa[15:0] = 16'hDEAD;

        repeat (3) @(posedge clk); #1;
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_drop", 32'(frame_drop), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Known frame, ready held high: byte order and 66-cycle duration.
        strobe(fa, 1'b1);
        check("start_valid", 32'(tx_valid), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("first_byte0", 32'(tx_byte), 32'(first_bytes[0]));
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            check("first_bytes", 32'(tx_byte), 32'(first_bytes[i]));
        end
        repeat (61) @(posedge clk); #1;
        check("busy_at_last", 32'(busy), 32'd1);
        check("done_at_last", 32'(frame_done), 32'd1);
        @(posedge clk); #1;
        check("idle_after_frame", 32'(busy), 32'd0);
        wait_idle();

        // Same frame with random backpressure.
        rdy_rand = 1'b1;
        strobe(fa, 1'b1);
        wait_idle();
        for (int r = 0; r < 3; r++) begin
            strobe(rand_frame(), 1'b1);
            wait_idle();
        end

        // Second strobe at byte 10.
        strobe(rand_frame(), 1'b1);
        wait_idx(10);
        strobe(rand_frame(), BUF);
        wait_idle();

        // Two extra strobes during one frame.
        strobe(rand_frame(), 1'b1);
        wait_idx(5);
        strobe(rand_frame(), BUF);
        wait_idx(20);
        strobe(rand_frame(), 1'b0);
        wait_idle();

        // Strobe coincident with the CRC_HI handshake, ready held high.
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);
        fy = rand_frame();
        fz = rand_frame();
        strobe(fy, 1'b1);
        repeat (64) @(posedge clk);
        strobe(fz, 1'b1);
        check("b2b_valid", 32'(tx_valid), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_byte0", 32'(tx_byte), 32'(fz[23:16]));
        wait_idle();

        // Reset in the middle of a frame.
        strobe(rand_frame(), 1'b1);
        wait_idx(30);
        rst = 1'b1;
        exp_q.delete();
        frames_exp--;
        #1;
        check("midrst_tx_byte", 32'(tx_byte), 32'd0);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_frame_drop", 32'(frame_drop), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        strobe(rand_frame(), 1'b1);
        wait_idle();
        repeat (3) @(posedge clk); #1;

        check("frames_done", 32'(done_cnt), 32'(frames_exp));
        check("frames_dropped", 32'(drop_cnt), 32'(drops_exp));
        check("no_gap", 32'(gap_seen), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
